// File: rtl/scratchpad_backdoor_arb_if.sv
// Bundle of requester, response and scratchpad backdoor signals for the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface scratchpad_backdoor_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*64-1:0]     req_wdata;
    logic [NUM_REQ*8-1:0]      req_mask;

    logic                      rsp_valid;
    logic [IDW-1:0]            rsp_id;
    logic                      rsp_write;
    logic                      rsp_err;
    logic [63:0]               rsp_rdata;

    logic                      mem_hold;
    logic                      mem_req;
    logic                      mem_write;
    logic [ADDR_W-1:0]         mem_addr;
    logic [63:0]               mem_wdata;
    logic [7:0]                mem_mask;
    logic [63:0]               mem_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_mask, mem_hold, mem_rdata,
        output req_ready, rsp_valid, rsp_id, rsp_write, rsp_err, rsp_rdata,
        output mem_req, mem_write, mem_addr, mem_wdata, mem_mask
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_mask, mem_hold, mem_rdata,
        input  req_ready, rsp_valid, rsp_id, rsp_write, rsp_err, rsp_rdata,
        input  mem_req, mem_write, mem_addr, mem_wdata, mem_mask
    );
endinterface

// File: rtl/scratchpad_backdoor_arb.sv
// Round-robin arbiter serialising 64-bit backdoor requests onto the scratchpad's
// single access port, one transaction in flight, registered-read timing.
module scratchpad_backdoor_arb #(
    parameter int          NUM_REQ   = 4,
    parameter int          ADDR_W    = 32,
    parameter int          DATA_W    = 64,
    parameter logic [31:0] MEM_BYTES = 32'h0001_0000
) (
    input logic                     clk,
    input logic                     rst_n,
    scratchpad_backdoor_arb_if.slave bus
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - 32'd8);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_e;

    state_e              state_q, state_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]      id_q, id_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [7:0]          mask_q, mask_d;

    logic [NUM_REQ-1:0]  grant;
    logic [IDW-1:0]      gidx;
    logic [IDW-1:0]      cand;
    logic                gany;
    logic                open;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic                sel_err;

    // Search starts just past the last winner so every waiting requester gets a turn.
    always_comb begin
        gany = 1'b0;
        gidx = '0;
        cand = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!gany && bus.req_valid[cand]) begin
                gany = 1'b1;
                gidx = cand;
            end
        end
        grant = gany ? (NUM_REQ'(1) << gidx) : '0;
    end

    assign open          = (state_q == IDLE) && !bus.mem_hold && rst_n;
    assign accept        = open && gany;
    assign bus.req_ready = open ? grant : '0;

    assign sel_addr = bus.req_addr[gidx*ADDR_W +: ADDR_W];
    assign sel_err  = (sel_addr[2:0] != 3'b000) || (sel_addr > MAX_ADDR);

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        wr_d     = wr_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    rr_ptr_d = gidx;
                    id_d     = gidx;
                    wr_d     = bus.req_write[gidx];
                    addr_d   = sel_addr;
                    wdata_d  = bus.req_wdata[gidx*64 +: 64];
                    mask_d   = bus.req_mask[gidx*8 +: 8];
                    err_d    = sel_err;
                    rdata_d  = '0;
                    state_d  = sel_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                if (!bus.mem_hold) state_d = wr_q ? RESP : RDWAIT;
            end
            RDWAIT: begin
                rdata_d = bus.mem_rdata;
                state_d = RESP;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= IDW'(NUM_REQ - 1);
            id_q     <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mask_q   <= mask_d;
        end
    end

    // Data lines stay at zero unless the strobe is up, so the memory never sees stale addresses.
    assign bus.mem_req   = (state_q == ISSUE) && !bus.mem_hold;
    assign bus.mem_write = bus.mem_req && wr_q;
    assign bus.mem_addr  = bus.mem_req ? addr_q  : '0;
    assign bus.mem_wdata = bus.mem_req ? wdata_q : '0;
    assign bus.mem_mask  = bus.mem_req ? mask_q  : '0;

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = bus.rsp_valid ? id_q    : '0;
    assign bus.rsp_write = bus.rsp_valid && wr_q;
    assign bus.rsp_err   = bus.rsp_valid && err_q;
    assign bus.rsp_rdata = bus.rsp_valid ? rdata_q : '0;
endmodule

// File: doc/scratchpad_backdoor_arb.md
# scratchpad_backdoor_arb

Arbitrated, sequenced backdoor access port for the scratchpad (main) memory. It accepts 64-bit read/write requests from up to NUM_REQ independent testbench requesters, such as the system driver and the per-CPU drivers. It serialises them with round-robin arbitration and drives the scratchpad's single backdoor write/read port with correct registered-read timing. This replaces ad-hoc multi-thread driving of the same memory signals with one owner that guarantees mutual exclusion and in-order completion per grant.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, byte-address width
- DATA_W, 64, data width; fixed at 64, access unit is one 8-byte word
- MEM_BYTES, 32'h0001_0000, scratchpad size in bytes; valid addresses are 0..MEM_BYTES-8
- clk  in  1  memory clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed byte addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*64  packed write data
- req_mask  in  NUM_REQ*8  packed byte-enable masks, writes only
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  $clog2(NUM_REQ)  requester index of the completing transaction
- rsp_write  out  1  completing transaction was a write
- rsp_err  out  1  transaction rejected: misaligned or out of range
- rsp_rdata  out  64  read data; 0 for writes and errors
- mem_hold  in  1  high while the memory is in reset or functional traffic owns the port
- mem_req  out  1  backdoor access strobe
- mem_write  out  1  write enable, qualified by mem_req
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  64  write data
- mem_mask  out  8  byte mask
- mem_rdata  in  64  registered read data, valid one cycle after the mem_req read cycle

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - The grant is computed combinationally from req_valid using round-robin, starting at rr_ptr+1 modulo NUM_REQ.
  - req_ready[g] = grant[g] when state==IDLE and mem_hold==0. All bits are 0 otherwise.
- Acceptance (req_valid[g] & req_ready[g]):
  - Latch id, write, addr, wdata and mask.
  - Set rr_ptr = g.
  - Check the address: err = (addr[2:0] != 0) or (addr > MEM_BYTES-8).
  - err → RESP. Otherwise → ISSUE.
- ISSUE:
  - mem_req = !mem_hold, with mem_write/addr/wdata/mask driven from the latched values.
  - Stay in ISSUE while mem_hold==1.
  - When mem_hold==0, the access completes this cycle. A write goes → RESP; a read goes → RDWAIT.
- RDWAIT: capture mem_rdata into the response register → RESP.
- RESP:
  - rsp_valid = 1, with rsp_id/write/err/rdata from the latched values → IDLE.
  - In RESP with err=1: rsp_rdata = 0 and no memory access has occurred.
- mem_* data outputs are 0 whenever mem_req==0, so the memory sees no spurious addresses.
- A requester must keep req_valid and its payload stable until req_ready is seen. Deasserting req_valid without acceptance is legal and simply drops the request from arbitration.
- Requesters with no valid request are skipped. A lone requester is granted on every IDLE pass.
- Exactly one transaction is outstanding at a time. Ordering is global acceptance order.
- mem_hold rising while in RDWAIT or RESP has no effect, because the access has already completed.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, rr_ptr = NUM_REQ-1 (requester 0 has first priority).
  - All outputs = 0, latched payload = 0.
  - An in-flight transaction is dropped with no rsp_valid.
- Read latency, accept edge T to rsp_valid:
  - ISSUE/mem_req in cycle T+1.
  - mem_rdata sampled at end of T+2.
  - rsp_valid in cycle T+3.
  - The next accept is possible at edge T+4.
- Write: mem_req in T+1, rsp_valid in T+2, next accept at T+3.
- Error: rsp_valid in T+1, with no mem_req.
- Each cycle mem_hold is high during ISSUE adds one cycle of latency. mem_req is never high while mem_hold is high.
- rsp_valid lasts exactly one cycle, with no backpressure.

## Test plan
- Single write then read: requester 0 writes 64'hDEADBEEF_CAFEF00D with mask 8'hFF to 0x100, then reads 0x100. Required: mem_req high 1 cycle with mem_write=1, rsp_valid at T+2 (rsp_write=1), read rsp_valid at T+3 with rsp_rdata=64'hDEADBEEF_CAFEF00D and rsp_id=0.
- Round-robin fairness: all 4 requesters hold continuous valid reads from reset. Required grant order 0,1,2,3,0,1,…; no requester is granted twice before the others; 8 responses with rsp_id sequence 0,1,2,3,0,1,2,3.
- Error paths:
  - Read at 0x104 → rsp_err=1, rsp_rdata=0, no mem_req, rsp in T+1.
  - Read at MEM_BYTES → rsp_err=1.
  - Read at MEM_BYTES-8 → rsp_err=0.
- mem_hold: mem_hold is high 5 cycles before a write is issued. Required: no req_ready while hold is high. Hold is then raised for 3 cycles during ISSUE; required: mem_req low during those cycles and write rsp_valid delayed by exactly 3 cycles.
- Reset mid-read: assert rst_n low in RDWAIT. Required: all outputs 0 immediately (asynchronous), no rsp_valid after release, and the first grant after reset goes to requester 0.
- Partial mask: write 64'h1111_2222_3333_4444 with mask 8'h0F over a word pre-filled with all-ones. Required: mem_mask=8'h0F and readback 64'hFFFF_FFFF_3333_4444 through the memory model.
